// File: rtl/cpu_mem_responder_if.sv
// Bus bundle between the dual-issue core (plus its streaming loader) and the
// memory-side responder.
interface cpu_mem_responder_if;
  logic [31:0] inst_addr;
  logic [63:0] inst_data;
  logic        mem_w;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  dwea;
  logic [31:0] rdata;
  logic        ld_start;
  logic        ld_valid;
  logic        ld_ready;
  logic [31:0] ld_data;
  logic        ld_last;
  logic        ld_done;
  logic        cpu_hold;
  logic [15:0] led_out;

  modport master (
    output inst_addr, mem_w, addr, wdata, dwea,
    output ld_start, ld_valid, ld_data, ld_last,
    input  inst_data, rdata, ld_ready, ld_done, cpu_hold, led_out
  );

  modport slave (
    input  inst_addr, mem_w, addr, wdata, dwea,
    input  ld_start, ld_valid, ld_data, ld_last,
    output inst_data, rdata, ld_ready, ld_done, cpu_hold, led_out
  );
endinterface

// File: rtl/cpu_mem_responder.sv
// Memory-side responder: dual-word instruction fetch, byte-lane data memory,
// small MMIO window and a streaming loader that fills IMEM while holding the core.
module cpu_mem_responder #(
  parameter int          IMEM_WORDS = 1024,
  parameter int          DMEM_WORDS = 1024,
  parameter logic [15:0] MMIO_PAGE  = 16'hFFFF
) (
  input  logic                clk,
  input  logic                rst,
  cpu_mem_responder_if.slave  bus
);

  localparam int IW = $clog2(IMEM_WORDS);
  localparam int DW = $clog2(DMEM_WORDS);
  localparam logic [IW-1:0] I_ONE = {{(IW-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  logic [31:0]   imem_r [IMEM_WORDS];
  logic [31:0]   dmem_r [DMEM_WORDS];
  logic [15:0]   led_r;
  logic [31:0]   cycle_r;
  state_t        state_r;
  state_t        state_next_s;
  logic [IW-1:0] ptr_r;
  logic          ld_ready_r;
  logic          cpu_hold_r;
  logic          ld_done_r;

  logic [IW-1:0] fetch_lo_s;
  logic [IW-1:0] fetch_hi_s;
  logic [DW-1:0] dw_idx_s;
  logic          is_mmio_s;
  logic          dmem_we_s;
  logic          led_we_s;
  logic          load_beat_s;
  logic [31:0]   lane_mask_s;
  logic [31:0]   rdata_s;
  logic          unused_s;

  assign fetch_lo_s  = bus.inst_addr[IW+1:2];
  assign fetch_hi_s  = fetch_lo_s + I_ONE;
  assign dw_idx_s    = bus.addr[DW+1:2];
  assign is_mmio_s   = (bus.addr[31:16] == MMIO_PAGE);
  assign dmem_we_s   = bus.mem_w && !is_mmio_s;
  assign led_we_s    = bus.mem_w && is_mmio_s && (bus.addr[15:0] == 16'h0000);
  assign load_beat_s = (state_r == ST_LOAD) && bus.ld_valid;
  assign lane_mask_s = {{8{bus.dwea[3]}}, {8{bus.dwea[2]}}, {8{bus.dwea[1]}}, {8{bus.dwea[0]}}};
  // Upper fetch address bits alias and the byte offset is ignored.
  assign unused_s    = ^{bus.inst_addr[31:IW+2], bus.inst_addr[1:0]};

  // Loader next-state logic.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (bus.ld_start) begin
          state_next_s = ST_LOAD;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_LOAD: begin
        if (bus.ld_valid && bus.ld_last) begin
          state_next_s = ST_DONE;
        end else begin
          state_next_s = ST_LOAD;
        end
      end
      ST_DONE: state_next_s = ST_IDLE;
      default: state_next_s = ST_IDLE;
    endcase
  end

  // Loader state plus registered handshake decodes of the upcoming state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      ld_ready_r <= 1'b0;
      cpu_hold_r <= 1'b0;
      ld_done_r  <= 1'b0;
    end else begin
      state_r    <= state_next_s;
      ld_ready_r <= (state_next_s == ST_LOAD);
      cpu_hold_r <= (state_next_s != ST_IDLE);
      ld_done_r  <= (state_next_s == ST_DONE);
    end
  end

  // Loader word pointer, restarted by each accepted ld_start.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_r <= {IW{1'b0}};
    end else if ((state_r == ST_IDLE) && bus.ld_start) begin
      ptr_r <= {IW{1'b0}};
    end else if (load_beat_s) begin
      ptr_r <= ptr_r + I_ONE;
    end else begin
      ptr_r <= ptr_r;
    end
  end

  // Instruction memory fill; contents survive rst.
  always_ff @(posedge clk) begin
    if (load_beat_s && !rst) begin
      imem_r[ptr_r] <= bus.ld_data;
    end
  end

  // Data memory byte-lane write; contents survive rst.
  always_ff @(posedge clk) begin
    if (dmem_we_s) begin
      dmem_r[dw_idx_s] <= (dmem_r[dw_idx_s] & ~lane_mask_s) | (bus.wdata & lane_mask_s);
    end
  end

  // MMIO registers: LED honours lanes 0/1, cycle counter free-runs.
  always_ff @(posedge clk) begin
    if (rst) begin
      led_r   <= 16'h0000;
      cycle_r <= 32'h0000_0000;
    end else begin
      cycle_r <= cycle_r + 32'd1;
      if (led_we_s) begin
        led_r <= (led_r & ~lane_mask_s[15:0]) | (bus.wdata[15:0] & lane_mask_s[15:0]);
      end else begin
        led_r <= led_r;
      end
    end
  end

  // Zero-latency load path: MMIO window or aliased DMEM word.
  always_comb begin
    rdata_s = 32'h0000_0000;
    if (is_mmio_s) begin
      case (bus.addr[15:0])
        16'h0000: rdata_s = {16'h0000, led_r};
        16'h0004: rdata_s = cycle_r;
        16'h0008: rdata_s = {31'd0, (state_r == ST_LOAD)};
        default:  rdata_s = 32'h0000_0000;
      endcase
    end else begin
      rdata_s = dmem_r[dw_idx_s];
    end
  end

  assign bus.inst_data = {imem_r[fetch_hi_s], imem_r[fetch_lo_s]};
  assign bus.rdata     = rdata_s;
  assign bus.ld_ready  = ld_ready_r;
  assign bus.cpu_hold  = cpu_hold_r;
  assign bus.ld_done   = ld_done_r;
  assign bus.led_out   = led_r;

endmodule

// File: tb/tb_cpu_mem_responder.sv
// Self-checking bench for cpu_mem_responder: directed table, loader corner
// sequences and randomized traffic against a behavioural memory model.
module tb_cpu_mem_responder;

  logic clk = 1'b0;
  logic rst;
  cpu_mem_responder_if bus ();

  cpu_mem_responder #(
    .IMEM_WORDS (1024),
    .DMEM_WORDS (1024),
    .MMIO_PAGE  (16'hFFFF)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;

  // Behavioural reference state.
  logic [31:0] imem_m [1024];
  logic [31:0] dmem_m [1024];
  logic [15:0] led_m;
  logic [31:0] cycle_m;
  bit          loading_m;
  bit          done_m;
  int          ptr_m;

  typedef struct {
    logic        we;
    logic [31:0] a;
    logic [31:0] wd;
    logic [3:0]  be;
    logic [31:0] exp_rd;
    logic [15:0] exp_led;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] model_rdata(input logic [31:0] a);
    if (a[31:16] == 16'hFFFF) begin
      case (a[15:0])
        16'h0000: return {16'h0000, led_m};
        16'h0004: return cycle_m;
        16'h0008: return {31'd0, loading_m};
        default:  return 32'h0;
      endcase
    end
    return dmem_m[a[11:2]];
  endfunction

  function automatic logic [63:0] model_inst(input logic [31:0] a);
    int i;
    i = (a >> 2) % 1024;
    return {imem_m[(i + 1) % 1024], imem_m[i]};
  endfunction

  // Advance one clock, applying the spec's rules to the model from the inputs at the edge.
  task automatic tick();
    @(posedge clk);
    if (rst) begin
      led_m = 16'h0; cycle_m = 32'h0; loading_m = 1'b0; done_m = 1'b0;
    end else begin
      cycle_m = cycle_m + 32'd1;
      if (bus.mem_w && bus.addr[31:16] != 16'hFFFF) begin
        for (int b = 0; b < 4; b++)
          if (bus.dwea[b]) dmem_m[bus.addr[11:2]][8*b +: 8] = bus.wdata[8*b +: 8];
      end
      if (bus.mem_w && bus.addr == 32'hFFFF_0000) begin
        if (bus.dwea[0]) led_m[7:0]  = bus.wdata[7:0];
        if (bus.dwea[1]) led_m[15:8] = bus.wdata[15:8];
      end
      if (done_m) begin
        done_m = 1'b0;
      end else if (loading_m) begin
        if (bus.ld_valid) begin
          imem_m[ptr_m] = bus.ld_data;
          ptr_m = (ptr_m + 1) % 1024;
          if (bus.ld_last) begin
            loading_m = 1'b0;
            done_m = 1'b1;
          end
        end
      end else if (bus.ld_start) begin
        loading_m = 1'b1;
        ptr_m = 0;
      end
    end
    #1;
  endtask

  task automatic check_all();
    #1;
    chk("rdata",     {32'h0, bus.rdata},     {32'h0, model_rdata(bus.addr)});
    chk("inst_data", bus.inst_data,          model_inst(bus.inst_addr));
    chk("led_out",   {48'h0, bus.led_out},   {48'h0, led_m});
    chk("ld_ready",  {63'h0, bus.ld_ready},  {63'h0, loading_m});
    chk("cpu_hold",  {63'h0, bus.cpu_hold},  {63'h0, (loading_m | done_m)});
    chk("ld_done",   {63'h0, bus.ld_done},   {63'h0, done_m});
  endtask

  task automatic idle_inputs();
    bus.mem_w = 1'b0; bus.addr = 32'h0; bus.wdata = 32'h0; bus.dwea = 4'h0;
    bus.ld_start = 1'b0; bus.ld_valid = 1'b0; bus.ld_data = 32'h0; bus.ld_last = 1'b0;
    bus.inst_addr = 32'h0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        tbl [14];
    logic [31:0] a_w [4];
    logic [31:0] b_w [2];
    logic [31:0] r1, r2, ra;

    a_w = '{32'hA000_00A0, 32'hA111_11A1, 32'hA222_22A2, 32'hA333_33A3};
    b_w = '{32'hB0B0_0000, 32'hB1B1_1111};
    tbl[0]  = '{1'b1, 32'h0000_0010, 32'h1122_3344, 4'hF, 32'hD000_0004, 16'h0000};
    tbl[1]  = '{1'b1, 32'h0000_0010, 32'hAABB_CCDD, 4'h5, 32'h1122_3344, 16'h0000};
    tbl[2]  = '{1'b1, 32'h0000_0010, 32'hFFFF_FFFF, 4'h0, 32'h11BB_33DD, 16'h0000};
    tbl[3]  = '{1'b0, 32'h0000_0010, 32'h0000_0000, 4'hF, 32'h11BB_33DD, 16'h0000};
    tbl[4]  = '{1'b0, 32'h0000_1010, 32'h0000_0000, 4'h0, 32'h11BB_33DD, 16'h0000};
    tbl[5]  = '{1'b1, 32'hFFFF_0000, 32'h0001_A5A5, 4'hF, 32'h0000_0000, 16'h0000};
    tbl[6]  = '{1'b0, 32'hFFFF_0000, 32'h0000_0000, 4'h0, 32'h0000_A5A5, 16'hA5A5};
    tbl[7]  = '{1'b1, 32'hFFFF_0000, 32'h1234_5678, 4'h1, 32'h0000_A5A5, 16'hA5A5};
    tbl[8]  = '{1'b0, 32'hFFFF_0000, 32'h0000_0000, 4'h0, 32'h0000_A578, 16'hA578};
    tbl[9]  = '{1'b1, 32'hFFFF_0008, 32'hFFFF_FFFF, 4'hF, 32'h0000_0000, 16'hA578};
    tbl[10] = '{1'b1, 32'hFFFF_0010, 32'hFFFF_FFFF, 4'hF, 32'h0000_0000, 16'hA578};
    tbl[11] = '{1'b0, 32'hFFFF_000C, 32'h0000_0000, 4'h0, 32'h0000_0000, 16'hA578};
    tbl[12] = '{1'b1, 32'hFFFE_0010, 32'hCAFE_F00D, 4'hF, 32'h11BB_33DD, 16'hA578};
    tbl[13] = '{1'b0, 32'h0000_0010, 32'h0000_0000, 4'h0, 32'hCAFE_F00D, 16'hA578};

    idle_inputs();
    rst = 1'b1;
    repeat (3) tick();
    bus.addr = 32'hFFFF_0004;
    #1;
    chk("rst_led",      {48'h0, bus.led_out},  64'h0);
    chk("rst_ld_ready", {63'h0, bus.ld_ready}, 64'h0);
    chk("rst_ld_done",  {63'h0, bus.ld_done},  64'h0);
    chk("rst_cpu_hold", {63'h0, bus.cpu_hold}, 64'h0);
    chk("rst_cycle",    {32'h0, bus.rdata},    64'h0);
    rst = 1'b0;

    // Known DMEM image, then a full-depth IMEM load.
    for (int i = 0; i < 1024; i++) begin
      bus.mem_w = 1'b1; bus.dwea = 4'hF;
      bus.addr = i * 4; bus.wdata = 32'hD000_0000 | i;
      tick();
    end
    idle_inputs();
    bus.ld_start = 1'b1;
    tick();
    bus.ld_start = 1'b0;
    for (int k = 0; k < 1024; k++) begin
      bus.ld_valid = 1'b1; bus.ld_data = $urandom; bus.ld_last = (k == 1023);
      tick();
    end
    idle_inputs();
    repeat (2) tick();
    check_all();

    for (int v = 0; v < 14; v++) begin
      bus.mem_w = tbl[v].we; bus.addr = tbl[v].a; bus.wdata = tbl[v].wd; bus.dwea = tbl[v].be;
      #1;
      chk($sformatf("tbl%0d_rdata", v), {32'h0, bus.rdata},   {32'h0, tbl[v].exp_rd});
      chk($sformatf("tbl%0d_led", v),   {48'h0, bus.led_out}, {48'h0, tbl[v].exp_led});
      tick();
    end
    idle_inputs();

    // Four-beat load of A0..A3.
    bus.ld_start = 1'b1;
    #1;
    chk("ld_hold_pre", {63'h0, bus.cpu_hold}, 64'h0);
    tick();
    bus.ld_start = 1'b0;
    #1;
    chk("ld_hold_on",  {63'h0, bus.cpu_hold}, 64'h1);
    chk("ld_ready_on", {63'h0, bus.ld_ready}, 64'h1);
    for (int k = 0; k < 4; k++) begin
      bus.ld_valid = 1'b1; bus.ld_data = a_w[k]; bus.ld_last = (k == 3);
      check_all();
      chk("ld_done_early", {63'h0, bus.ld_done}, 64'h0);
      tick();
    end
    bus.ld_valid = 1'b0; bus.ld_last = 1'b0;
    #1;
    chk("ld_done_pulse", {63'h0, bus.ld_done},  64'h1);
    chk("ld_hold_done",  {63'h0, bus.cpu_hold}, 64'h1);
    chk("ld_ready_done", {63'h0, bus.ld_ready}, 64'h0);
    tick();
    #1;
    chk("ld_done_end", {63'h0, bus.ld_done},  64'h0);
    chk("ld_hold_end", {63'h0, bus.cpu_hold}, 64'h0);
    bus.inst_addr = 32'h0000_0008;
    #1;
    chk("fetch_8", bus.inst_data, {a_w[3], a_w[2]});
    bus.inst_addr = 32'h0000_0FFC;
    #1;
    chk("fetch_wrap", bus.inst_data, {a_w[0], imem_m[1023]});
    bus.inst_addr = 32'h0001_100B;
    check_all();

    // Cycle counter after a fresh reset.
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    bus.addr = 32'hFFFF_0004;
    repeat (10) tick();
    #1;
    r1 = bus.rdata;
    chk("cycle_at10", {32'h0, r1}, 64'd10);
    repeat (5) tick();
    #1;
    r2 = bus.rdata;
    chk("cycle_delta", {32'h0, r2 - r1}, 64'd5);
    bus.mem_w = 1'b1; bus.wdata = 32'h0; bus.dwea = 4'hF;
    tick();
    bus.mem_w = 1'b0;
    #1;
    chk("cycle_wr_ignored", {32'h0, bus.rdata}, 64'd16);
    check_all();

    // Reset in the middle of a four-beat load.
    idle_inputs();
    bus.ld_start = 1'b1;
    tick();
    bus.ld_start = 1'b0;
    for (int k = 0; k < 2; k++) begin
      bus.ld_valid = 1'b1; bus.ld_data = b_w[k];
      tick();
    end
    bus.ld_valid = 1'b0;
    rst = 1'b1;
    tick();
    #1;
    chk("rst_mid_ready", {63'h0, bus.ld_ready}, 64'h0);
    chk("rst_mid_hold",  {63'h0, bus.cpu_hold}, 64'h0);
    chk("rst_mid_done",  {63'h0, bus.ld_done},  64'h0);
    rst = 1'b0;
    for (int k = 0; k < 2; k++) begin
      tick();
      #1;
      chk("rst_mid_nodone", {63'h0, bus.ld_done}, 64'h0);
    end
    bus.inst_addr = 32'h0;
    #1;
    chk("rst_mid_kept01", bus.inst_data, {b_w[1], b_w[0]});
    bus.inst_addr = 32'h8;
    #1;
    chk("rst_mid_kept23", bus.inst_data, {a_w[3], a_w[2]});

    // Randomized traffic on every port against the model.
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        ra = {16'hFFFF, 16'h0000} | ($urandom_range(0, 4) * 4);
      end else begin
        ra = $urandom;
        if (ra[31:16] == 16'hFFFF) ra[31:16] = 16'h0000;
      end
      bus.addr = ra;
      bus.mem_w = $urandom_range(0, 1);
      bus.wdata = $urandom;
      bus.dwea = $urandom_range(0, 15);
      bus.inst_addr = $urandom;
      bus.ld_start = ($urandom_range(0, 19) == 0);
      bus.ld_valid = $urandom_range(0, 1);
      bus.ld_data = $urandom;
      bus.ld_last = ($urandom_range(0, 9) == 0);
      check_all();
      tick();
    end
    idle_inputs();
    check_all();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
